modbus_frame_rx: RTL and testbench
==================================

# modbus_frame_rx

Modbus RTU request-frame receiver: the inbound counterpart of the response transmitter on the same RS485 link. It takes bytes from the UART byte receiver and delimits frames by line silence (t1.5/t3.5). It checks length, inter-byte gap, CRC-16 and slave address. On an accepted 8-byte request it pulses `frame_valid` with the decoded fields; downstream logic uses that pulse to build the reply and start the transmitter.

## Interface
- `CLK_FREQ`, default 50000000: system clock in Hz.
- `BAUD_RATE`, default 9600: line rate.
- Derived constants:
  - `BPS_PARAM = CLK_FREQ/BAUD_RATE`.
  - `T15 = 15*BPS_PARAM`.
  - `T35 = 35*BPS_PARAM`.
  - Requirements: `T35 < 2^24` and `BPS_PARAM >= 16`.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte, valid while `rx_done` is high.
- `rx_done` in 1: one-cycle pulse per received byte from the UART byte receiver.
- `rx_inhibit` in 1: high while our own transmitter drives the bus (tie to `rs485_tx_en`).
- `dev_addr` in 8: this slave's address.
- `frame_valid` out 1: one-cycle pulse, accepted frame.
- `rx_func_code` out 8: byte 1 of the last accepted frame.
- `rx_reg_addr` out 16: bytes 2..3 of the frame, big-endian.
- `rx_reg_data` out 16: bytes 4..5 of the frame, big-endian (quantity or value).
- `frame_err` out 1: one-cycle pulse, frame rejected.
- `err_code` out 2: 1 = length, 2 = gap, 3 = CRC. Valid with `frame_err`, held afterwards.
- `rx_busy` out 1: high while in RECV or CHECK.
- Reset values: all outputs 0.

## Operation
- Silence counter `sil_cnt` (24 bit):
  - Cleared on every cycle `rx_done` is accepted.
  - Otherwise increments each clock, saturating at `T35`.
  - Reset value 0.
- State WAIT (state after reset): waits for `sil_cnt == T35`, then goes to IDLE. Bytes arriving in WAIT restart the count and are discarded.
- State IDLE: on `rx_done`:
  - store the byte in `buf[0]`;
  - `byte_cnt = 1`;
  - clear flags `ovf` and `gap`;
  - load `crc = 0xFFFF ^ rx_data` and start the CRC update;
  - go to RECV.
- State RECV:
  - On `rx_done` with `byte_cnt < 8`: store into `buf[byte_cnt]`, `byte_cnt++`, run the CRC update.
  - On `rx_done` with `byte_cnt == 8`: set `ovf`; the byte is not stored and not CRC'd.
  - If a byte arrives when `sil_cnt >= T15`: set `gap`, but still store the byte.
  - When `sil_cnt` reaches `T35`: go to CHECK.
- CRC update (Modbus, reflected poly 0xA001):
  - Bit-serial, 8 clocks per byte: `crc = crc[0] ? (crc>>1)^0xA001 : crc>>1`.
  - The XOR of each new byte into the low 8 bits happens on the accept cycle.
  - Completes long before the next `rx_done` (guaranteed by `BPS_PARAM >= 16`).
  - Over all 8 bytes including the CRC, a good frame leaves residual `0x0000`.
- State CHECK (one cycle), evaluated in priority order:
  1. `byte_cnt != 8` or `ovf` -> error 1.
  2. `gap` -> error 2.
  3. `crc != 0` -> error 3.
  4. `buf[0] != dev_addr` -> silent discard: no pulse, field outputs unchanged.
  5. Otherwise `frame_valid` pulses and `rx_func_code`/`rx_reg_addr`/`rx_reg_data` load from `buf[1..5]`.
  - CHECK always returns to IDLE.
- Output holding: field outputs and `err_code` hold until the next update.
- `rx_inhibit` high, from any state:
  - go to IDLE and discard the partial frame (no pulse);
  - ignore `rx_done`;
  - hold `sil_cnt` at 0.
  - After `rx_inhibit` falls, the block is in IDLE; no fresh t3.5 is required.
- Reset mid-frame: everything returns to reset values and the state machine to WAIT.

## Timing
- Pulse timing: the `frame_valid`/`frame_err` pulse occurs exactly `T35 + 2` clocks after the last accepted `rx_done` cycle (`T35` counts, +1 into CHECK, +1 registered output). Pulse width is exactly 1 clock.
- Field outputs change on the same edge that raises `frame_valid`.
- `rx_busy` rises the cycle after the first `rx_done` and falls with the pulse edge.
- Simultaneous events:
  - `rx_done` on the same cycle `sil_cnt` would reach `T35` in RECV: the byte wins. It is stored, the count clears, and the block stays in RECV.
  - `rx_done` in the same cycle as `rx_inhibit`: inhibit wins.
- A byte arriving in IDLE one clock after a CHECK cycle starts a new frame normally.

## Test plan
Common setup: `CLK_FREQ=1600000`, `BAUD_RATE=100000` (`BPS_PARAM=16`, `T15=240`, `T35=560`), `dev_addr=0x01`, wait 600 clocks after reset, bytes spaced 160 clocks apart.

1. Send 01 03 00 00 00 01 84 0A -> `frame_valid` 1 clock, 562 clocks after the last `rx_done`; `rx_func_code=0x03`, `rx_reg_addr=0x0000`, `rx_reg_data=0x0001`; `frame_err` stays 0.
2. Same frame with last byte 0B -> `frame_err`, `err_code=3`, fields unchanged from scenario 1.
3. Same frame with the gap between bytes 3 and 4 set to 300 clocks -> `frame_err`, `err_code=2`. Nine-byte frame (extra 00) -> `err_code=1`. Six-byte frame -> `err_code=1`.
4. Valid frame addressed to 02 (correct CRC, 02 03 00 00 00 01 84 39) -> no pulse on either output; outputs unchanged.
5. Raise `rx_inhibit` after 4 bytes for 1000 clocks, then send the scenario-1 frame -> no pulse for the partial frame, then one `frame_valid` with the scenario-1 fields.
6. Assert `rst_n_in` after 5 bytes, then release and immediately send the scenario-1 frame -> frame ignored (WAIT). A second copy sent 600 clocks later -> `frame_valid`.

Source files
------------

// File: rtl/modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// modbus_frame_rx
//   Modbus RTU request-frame receiver. Bytes from the UART byte receiver are
//   grouped into frames by line silence (t1.5 / t3.5). A completed frame is
//   checked for length, inter-byte gap, CRC-16 and slave address. An accepted
//   8-byte request pulses frame_valid and presents its decoded fields.
//
// Parameters
//   CLK_FREQ      system clock in Hz
//   BAUD_RATE     line rate in bit/s
//
// Ports
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset
//   rx_data       received byte, valid while rx_done is high
//   rx_done       one-cycle pulse per received byte
//   rx_inhibit    high while our own transmitter drives the bus
//   dev_addr      this slave's address
//   frame_valid   one-cycle pulse, frame accepted
//   rx_func_code  byte 1 of the last accepted frame
//   rx_reg_addr   bytes 2..3 of the last accepted frame, big-endian
//   rx_reg_data   bytes 4..5 of the last accepted frame, big-endian
//   frame_err     one-cycle pulse, frame rejected
//   err_code      1 = length, 2 = gap, 3 = CRC; held after frame_err
//   rx_busy       high while a frame is being received or checked
// -----------------------------------------------------------------------------
module modbus_frame_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_inhibit,
  input  logic [7:0]  dev_addr,
  output logic        frame_valid,
  output logic [7:0]  rx_func_code,
  output logic [15:0] rx_reg_addr,
  output logic [15:0] rx_reg_data,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        rx_busy
);

  localparam int          BPS_PARAM = CLK_FREQ / BAUD_RATE;
  localparam logic [23:0] T15       = 24'(15 * BPS_PARAM);
  localparam logic [23:0] T35       = 24'(35 * BPS_PARAM);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_GAP = 2'd2;
  localparam logic [1:0] ERR_CRC = 2'd3;

  localparam logic [3:0] FRAME_LEN = 4'd8;

  logic [1:0]  state;
  logic [23:0] sil_cnt;
  logic [3:0]  byte_cnt;
  logic        ovf;
  logic        gap;
  logic [15:0] crc;
  logic [3:0]  crc_bits;
  // Only the payload bytes are kept; the two CRC bytes matter solely
  // through their effect on the running CRC residual.
  logic [7:0]  frame_buf [0:5];

  assign rx_busy = (state == ST_RECV) || (state == ST_CHECK);

  // Line-silence timer. Any byte (accepted or not by the FSM) proves the
  // line is active; while we transmit ourselves the line is treated as busy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sil_cnt <= '0;
    end else if (rx_inhibit || rx_done) begin
      sil_cnt <= '0;
    end else if (sil_cnt < T35) begin
      sil_cnt <= sil_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_WAIT;
      byte_cnt     <= '0;
      ovf          <= 1'b0;
      gap          <= 1'b0;
      crc          <= '0;
      crc_bits     <= '0;
      for (int i = 0; i < 6; i++) frame_buf[i] <= '0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= '0;
      rx_func_code <= '0;
      rx_reg_addr  <= '0;
      rx_reg_data  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      // Bit-serial CRC: one shift per clock for eight clocks after each
      // byte is XORed in. A byte accept below overrides this and restarts.
      if (crc_bits != 4'd0) begin
        crc      <= crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        crc_bits <= crc_bits - 4'd1;
      end

      if (rx_inhibit) begin
        // Our own transmission is on the bus: drop any partial frame and
        // be ready for the master's next request as soon as the bus frees.
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_WAIT: begin
            if (!rx_done && (sil_cnt == T35)) state <= ST_IDLE;
          end

          ST_IDLE: begin
            if (rx_done) begin
              frame_buf[0] <= rx_data;
              byte_cnt     <= 4'd1;
              ovf          <= 1'b0;
              gap          <= 1'b0;
              crc          <= 16'hFFFF ^ {8'h00, rx_data};
              crc_bits     <= 4'd8;
              state        <= ST_RECV;
            end
          end

          ST_RECV: begin
            // A byte takes priority over end-of-frame silence.
            if (rx_done) begin
              if (sil_cnt >= T15) gap <= 1'b1;
              if (byte_cnt == FRAME_LEN) begin
                ovf <= 1'b1;
              end else begin
                for (int i = 1; i < 6; i++) begin
                  if (byte_cnt == 4'(i)) frame_buf[i] <= rx_data;
                end
                byte_cnt <= byte_cnt + 4'd1;
                crc      <= crc ^ {8'h00, rx_data};
                crc_bits <= 4'd8;
              end
            end else if (sil_cnt == T35) begin
              state <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            state <= ST_IDLE;
            if ((byte_cnt != FRAME_LEN) || ovf) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else if (gap) begin
              frame_err <= 1'b1;
              err_code  <= ERR_GAP;
            end else if (crc != 16'h0000) begin
              frame_err <= 1'b1;
              err_code  <= ERR_CRC;
            end else if (frame_buf[0] == dev_addr) begin
              // Frames for other slaves fall through silently.
              frame_valid  <= 1'b1;
              rx_func_code <= frame_buf[1];
              rx_reg_addr  <= {frame_buf[2], frame_buf[3]};
              rx_reg_data  <= {frame_buf[4], frame_buf[5]};
            end
          end

          default: state <= ST_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_modbus_frame_rx
//   Directed bench for modbus_frame_rx at BPS_PARAM=16 (T15=240, T35=560).
//   Bytes are presented 160 clocks apart; result pulses are timed in clocks
//   from the accept edge of the last byte.
// -----------------------------------------------------------------------------
module tb_modbus_frame_rx;

  logic        clk_in;
  logic        rst_n_in;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_inhibit;
  logic [7:0]  dev_addr;
  logic        frame_valid;
  logic [7:0]  rx_func_code;
  logic [15:0] rx_reg_addr;
  logic [15:0] rx_reg_data;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        rx_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frm [0:8];

  int validAt, errAt, validCnt, errCnt;

  modbus_frame_rx #(
    .CLK_FREQ (1600000),
    .BAUD_RATE(100000)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_inhibit  (rx_inhibit),
    .dev_addr    (dev_addr),
    .frame_valid (frame_valid),
    .rx_func_code(rx_func_code),
    .rx_reg_addr (rx_reg_addr),
    .rx_reg_data (rx_reg_data),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .rx_busy     (rx_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sends frm[0..n-1]; the byte at index gapIdx follows its predecessor by
  // gapLen clocks instead of 160. Returns on the negedge after the last
  // byte's accept edge.
  task automatic applyStimulus(input int n, input int gapIdx, input int gapLen);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (((i == gapIdx) ? gapLen : 160) - 2) @(negedge clk_in);
      @(negedge clk_in);
      rx_data = frm[i];
      rx_done = 1'b1;
      @(negedge clk_in);
      rx_done = 1'b0;
    end
  endtask

  // Watches limit clocks, recording first-pulse position and pulse counts.
  task automatic watchResult(input int limit);
    validAt  = -1;
    errAt    = -1;
    validCnt = 0;
    errCnt   = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk_in);
      #1;
      if (frame_valid) begin
        validCnt++;
        if (validAt < 0) validAt = k;
      end
      if (frame_err) begin
        errCnt++;
        if (errAt < 0) errAt = k;
      end
    end
  endtask

  task automatic loadGoodFrame();
    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A, 8'h00};
  endtask

  initial begin
    rst_n_in   = 1'b0;
    rx_data    = 8'h00;
    rx_done    = 1'b0;
    rx_inhibit = 1'b0;
    dev_addr   = 8'h01;
    loadGoodFrame();

    repeat (3) @(negedge clk_in);
    checkOutput("rst_valid", 32'(frame_valid), 32'd0);
    checkOutput("rst_err", 32'(frame_err), 32'd0);
    checkOutput("rst_code", 32'(err_code), 32'd0);
    checkOutput("rst_func", 32'(rx_func_code), 32'd0);
    checkOutput("rst_addr", 32'(rx_reg_addr), 32'd0);
    checkOutput("rst_data", 32'(rx_reg_data), 32'd0);
    checkOutput("rst_busy", 32'(rx_busy), 32'd0);

    rst_n_in = 1'b1;
    repeat (600) @(negedge clk_in);
    checkOutput("idle_busy", 32'(rx_busy), 32'd0);

    // Scenario 1: good frame
    applyStimulus(8, -1, 0);
    checkOutput("s1_busy_recv", 32'(rx_busy), 32'd1);
    watchResult(700);
    checkOutput("s1_valid_at", 32'(validAt), 32'd562);
    checkOutput("s1_valid_cnt", 32'(validCnt), 32'd1);
    checkOutput("s1_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("s1_func", 32'(rx_func_code), 32'h03);
    checkOutput("s1_addr", 32'(rx_reg_addr), 32'h0000);
    checkOutput("s1_data", 32'(rx_reg_data), 32'h0001);
    checkOutput("s1_busy_done", 32'(rx_busy), 32'd0);

    // Scenario 2: CRC error
    repeat (20) @(negedge clk_in);
    frm[7] = 8'h0B;
    applyStimulus(8, -1, 0);
    watchResult(700);
    checkOutput("s2_err_at", 32'(errAt), 32'd562);
    checkOutput("s2_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("s2_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s2_code", 32'(err_code), 32'd3);
    checkOutput("s2_func", 32'(rx_func_code), 32'h03);
    checkOutput("s2_addr", 32'(rx_reg_addr), 32'h0000);
    checkOutput("s2_data", 32'(rx_reg_data), 32'h0001);

    // Scenario 3a: 300-clock gap before the fourth byte
    repeat (20) @(negedge clk_in);
    loadGoodFrame();
    applyStimulus(8, 3, 300);
    watchResult(700);
    checkOutput("s3a_err_at", 32'(errAt), 32'd562);
    checkOutput("s3a_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("s3a_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s3a_code", 32'(err_code), 32'd2);

    // Scenario 3b: six-byte frame
    repeat (20) @(negedge clk_in);
    applyStimulus(6, -1, 0);
    watchResult(700);
    checkOutput("s3b_err_at", 32'(errAt), 32'd562);
    checkOutput("s3b_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("s3b_code", 32'(err_code), 32'd1);

    // Scenario 3c: nine-byte frame, preceded by a CRC error so the
    // length code is a fresh update
    repeat (20) @(negedge clk_in);
    frm[7] = 8'h0B;
    applyStimulus(8, -1, 0);
    watchResult(700);
    checkOutput("s3c_pre_code", 32'(err_code), 32'd3);
    repeat (20) @(negedge clk_in);
    loadGoodFrame();
    applyStimulus(9, -1, 0);
    watchResult(700);
    checkOutput("s3c_err_at", 32'(errAt), 32'd562);
    checkOutput("s3c_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("s3c_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s3c_code", 32'(err_code), 32'd1);

    // Scenario 4: good frame for slave 02
    repeat (20) @(negedge clk_in);
    frm = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h39, 8'h00};
    applyStimulus(8, -1, 0);
    watchResult(700);
    checkOutput("s4_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s4_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("s4_code", 32'(err_code), 32'd1);
    checkOutput("s4_func", 32'(rx_func_code), 32'h03);
    checkOutput("s4_busy", 32'(rx_busy), 32'd0);

    // Scenario 5: inhibit after four bytes, then a good frame
    repeat (20) @(negedge clk_in);
    loadGoodFrame();
    applyStimulus(4, -1, 0);
    @(negedge clk_in);
    rx_inhibit = 1'b1;
    watchResult(1000);
    checkOutput("s5_inh_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s5_inh_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("s5_inh_busy", 32'(rx_busy), 32'd0);
    @(negedge clk_in);
    rx_inhibit = 1'b0;
    applyStimulus(8, -1, 0);
    watchResult(700);
    checkOutput("s5_valid_at", 32'(validAt), 32'd562);
    checkOutput("s5_valid_cnt", 32'(validCnt), 32'd1);
    checkOutput("s5_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("s5_data", 32'(rx_reg_data), 32'h0001);

    // Scenario 6: reset mid-frame, frame straight after reset is ignored
    repeat (20) @(negedge clk_in);
    applyStimulus(5, -1, 0);
    repeat (10) @(negedge clk_in);
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("s6_rst_func", 32'(rx_func_code), 32'd0);
    checkOutput("s6_rst_data", 32'(rx_reg_data), 32'd0);
    checkOutput("s6_rst_code", 32'(err_code), 32'd0);
    checkOutput("s6_rst_busy", 32'(rx_busy), 32'd0);
    rst_n_in = 1'b1;
    applyStimulus(8, -1, 0);
    checkOutput("s6_wait_busy", 32'(rx_busy), 32'd0);
    watchResult(700);
    checkOutput("s6_wait_valid_cnt", 32'(validCnt), 32'd0);
    checkOutput("s6_wait_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("s6_wait_func", 32'(rx_func_code), 32'd0);
    applyStimulus(8, -1, 0);
    watchResult(700);
    checkOutput("s6_valid_at", 32'(validAt), 32'd562);
    checkOutput("s6_valid_cnt", 32'(validCnt), 32'd1);
    checkOutput("s6_func", 32'(rx_func_code), 32'h03);
    checkOutput("s6_addr", 32'(rx_reg_addr), 32'h0000);
    checkOutput("s6_data", 32'(rx_reg_data), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
